// File: rtl/adder_pkg.sv
// adder_pkg: shared types, constants and helpers for the serial adder datapath
package adder_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} serial_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/carry_lookahead_adder_4bits.sv
// carry_lookahead_adder_4bits: 4-bit lookahead adder slice with group propagate/generate
module carry_lookahead_adder_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] sum,
  output logic       carry_out,
  output logic       PG,
  output logic       GG
);
  logic [3:0] p, g, c;
  // flat lookahead carries so the slice is one gate level deep per carry
  always_comb begin
    p = a ^ b;
    g = a & b;
    c[0] = carry_in;
    c[1] = g[0] | (p[0] & carry_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_in);
    PG = &p;
    GG = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    carry_out = GG | (PG & carry_in);
    sum = p ^ c;
  end
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit add computed one nibble per cycle through a single 4-bit slice
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW = clog2(NIB);
  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end
  serial_state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic carry_r, sign_a, sign_b, carry_out_r, overflow_r;
  logic [NIBBLE_W-1:0] slice_sum;
  logic slice_co, slice_pg_unused, slice_gg_unused;
  logic last;
  carry_lookahead_adder_4bits u_slice (
    .a        (a_r[NIBBLE_W-1:0]),
    .b        (b_r[NIBBLE_W-1:0]),
    .carry_in (carry_r),
    .sum      (slice_sum),
    .carry_out(slice_co),
    .PG       (slice_pg_unused),
    .GG       (slice_gg_unused)
  );
  assign last = cnt == CW'(NIB - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign sum = sum_r;
  assign carry_out = carry_out_r;
  assign overflow = overflow_r;
  // capture on accept, shift one nibble per BUSY cycle, freeze results in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      carry_r <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      carry_out_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= in0;
          b_r <= in1;
          carry_r <= carry_in;
          sign_a <= in0[WIDTH-1];
          sign_b <= in1[WIDTH-1];
          cnt <= '0;
          state <= BUSY;
        end
        BUSY: begin
          sum_r <= {slice_sum, sum_r[WIDTH-1:NIBBLE_W]};
          a_r <= a_r >> NIBBLE_W;
          b_r <= b_r >> NIBBLE_W;
          carry_r <= slice_co;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            carry_out_r <= slice_co;
            overflow_r <= (sign_a == sign_b) & (slice_sum[NIBBLE_W-1] != sign_a);
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed checks of the serial adder at WIDTH=32 and WIDTH=8
module tb_nibble_serial_adder;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, out_ready = 0, carry_in = 0;
  logic [31:0] in0 = 0, in1 = 0;
  logic in_ready, out_valid, carry_out, overflow;
  logic [31:0] sum;
  logic in_valid_8 = 0, out_ready_8 = 0, carry_in_8 = 0;
  logic [7:0] in0_8 = 0, in1_8 = 0;
  logic in_ready_8, out_valid_8, carry_out_8, overflow_8;
  logic [7:0] sum_8;
  int errors = 0, checks = 0, cyc = 0, lat, n, gap;
  int acc_q[$];
  always #5 clk = ~clk;
  nibble_serial_adder #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );
  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
    .in0(in0_8), .in1(in1_8), .carry_in(carry_in_8), .out_valid(out_valid_8),
    .out_ready(out_ready_8), .sum(sum_8), .carry_out(carry_out_8), .overflow(overflow_8)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (in_valid && in_ready) acc_q.push_back(cyc);
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic ci, output int l);
    @(negedge clk);
    in0 = a; in1 = b; carry_in = ci; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0; in0 = ~a; in1 = ~b; carry_in = ~ci;
    l = 0;
    while (!out_valid && l < 40) begin
      @(posedge clk); #1; l++;
    end
  endtask
  task automatic release32();
    out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask
  initial begin
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_sum", sum, 0);
    check("rst_carry", 32'(carry_out), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_sum8", 32'(sum_8), 0);
    @(negedge clk) rst_n = 1;
    run32(32'h0000_0001, 32'h0000_0001, 0, lat);
    check("op1_latency", lat, 8);
    check("op1_sum", sum, 32'h0000_0002);
    check("op1_carry", 32'(carry_out), 0);
    check("op1_ovf", 32'(overflow), 0);
    release32();
    check("op1_in_ready_after", 32'(in_ready), 1);
    run32(32'hFFFF_FFFF, 32'h0000_0000, 1, lat);
    check("ripple_sum", sum, 32'h0000_0000);
    check("ripple_carry", 32'(carry_out), 1);
    check("ripple_ovf", 32'(overflow), 0);
    release32();
    run32(32'h7FFF_FFFF, 32'h0000_0001, 0, lat);
    check("sovf_sum", sum, 32'h8000_0000);
    check("sovf_ovf", 32'(overflow), 1);
    check("sovf_carry", 32'(carry_out), 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_sum", sum, 32'h8000_0000);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_valid", 32'(out_valid), 1);
    end
    out_ready = 1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 1);
    check("bp_release_out_valid", 32'(out_valid), 0);
    out_ready = 0;
    @(negedge clk);
    acc_q.delete();
    in0 = 32'd3; in1 = 32'd4; carry_in = 0; in_valid = 1; out_ready = 1;
    n = 0;
    while (acc_q.size() < 2 && n < 40) begin
      @(posedge clk); n++;
    end
    gap = acc_q.size() >= 2 ? acc_q[1] - acc_q[0] : -1;
    check("b2b_spacing", gap, 10);
    @(negedge clk) in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("b2b_sum", sum, 32'd7);
    @(posedge clk); #1 out_ready = 0;
    check("b2b_idle", 32'(in_ready), 1);
    @(negedge clk);
    in0 = 32'h1234_5678; in1 = 32'h1111_1111; carry_in = 0; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_sum", sum, 0);
    @(negedge clk) rst_n = 1;
    run32(32'h1234_5678, 32'h1111_1111, 0, lat);
    check("post_rst_latency", lat, 8);
    check("post_rst_sum", sum, 32'h2345_6789);
    check("post_rst_carry", 32'(carry_out), 0);
    check("post_rst_ovf", 32'(overflow), 0);
    release32();
    @(negedge clk);
    in0_8 = 8'h9C; in1_8 = 8'hA5; carry_in_8 = 0; in_valid_8 = 1;
    @(posedge clk); #1 in_valid_8 = 0; in0_8 = 8'h00; in1_8 = 8'h00;
    lat = 0;
    while (!out_valid_8 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    check("w8_latency", lat, 2);
    check("w8_sum", 32'(sum_8), 32'h41);
    check("w8_carry", 32'(carry_out_8), 1);
    check("w8_ovf", 32'(overflow_8), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
